rtp_rx_depack: RTL and testbench
================================

# rtp_rx_depack

Receive-side RTP depacketizer for the WM8731 audio-over-Ethernet path. It consumes the UDP receive byte stream (udp_rec_*), validates the 12-byte RTP header against the same header/SSRC constants the transmit packer uses, and unpacks big-endian 16-bit samples into a jitter FIFO. It replays those samples to the codec DAC, one per sample request, with prefill and underflow recovery.

## Interface
- RTP_HEADER_PARAM, 16'h8080: expected bytes 0–1. Byte 0 must match exactly; byte 1 is compared with bit 7 (marker) masked.
- SSRC, 32'h12345678: expected SSRC, bytes 8–11.
- FIFO_DEPTH, 1024: sample FIFO depth, power of two.
- PREFILL, 474: FIFO level at which playback starts. 474 = one 960-byte packet.

- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- udp_rec_data_valid  in  1  one received byte this cycle.
- udp_rec_rdata  in  8  received byte.
- udp_rec_data_length  in  16  UDP payload length in bytes; sampled on the first byte of each packet.
- wav_rden  in  1  DAC sample request strobe, 1 cycle.
- wav_out_data  out  16  signed sample to the DAC.
- wav_out_valid  out  1  1-cycle pulse carrying wav_out_data.
- playing  out  1  playback active.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt, overflow_cnt, underflow_cnt  out  16 each  saturating event counters.

## Operation
- Parser states: IDLE, HDR, PAYLOAD, DISCARD. Bytes advance only on udp_rec_data_valid; gaps between bytes are allowed in every state.
- IDLE, on a valid byte:
  - Latch len = udp_rec_data_length and set byte_idx = 0.
  - The packet is marked bad if len < 14 or (len − 12) is odd.
  - Byte 0 is checked, then the parser goes to HDR.
  - len 0 or 1: the single byte is the whole packet. Count a drop and stay in IDLE.
- HDR, bytes 1–11:
  - Check byte 1 (masked) and bytes 8–11 against SSRC; any mismatch marks the packet bad.
  - Bytes 2–3 form seq (big-endian); they are not checked.
  - Bytes 4–7 (timestamp) are ignored.
  - Packet end (byte_idx == len−1) inside HDR → pkt_drop_cnt++, go to IDLE.
  - At byte 11, bad → pkt_drop_cnt++, go to DISCARD.
  - At byte 11, good → pkt_ok_cnt++, go to PAYLOAD.
  - Sequence check on a good packet: if a previous good packet exists and seq ≠ prev_seq+1 (mod 2^16), seq_gap_cnt++. Then prev_seq ← seq. 0xFFFF → 0x0000 is not a gap.
- PAYLOAD:
  - An even byte_idx latches the high byte.
  - An odd byte_idx writes {hi, byte} to the FIFO. If the FIFO is full at that cycle, the sample is dropped and overflow_cnt++.
  - At byte_idx == len−1 → IDLE.
- DISCARD: consume bytes until byte_idx == len−1, then go to IDLE.
- Playback:
  - playing sets when fifo_level ≥ PREFILL.
  - wav_rden with playing=1 and FIFO not empty → pop one sample.
  - wav_rden with playing=1 and FIFO empty → output 0, underflow_cnt++, clear playing. The FIFO then re-prefills.
  - wav_rden with playing=0 → output 0; nothing is counted.
- Counters saturate at 0xFFFF.

## Timing
- Reset outputs: wav_out_data=0, wav_out_valid=0, playing=0, fifo_level=0, all counters 0.
- Reset also clears state to IDLE, empties the FIFO and clears the "previous seq" flag.
- rst_n is only asserted between packets. A reset mid-packet makes the next valid byte start a new packet.
- wav_rden in cycle N → wav_out_valid=1 and wav_out_data in cycle N+1. The output holds its value until the next pulse.
- FIFO write to fifo_level: +1 the cycle after the write.
- playing rises the cycle after fifo_level ≥ PREFILL.
- A pop can occur in that same cycle, or any later cycle.
- Simultaneous write and pop: both happen and the level is unchanged.
- Full and empty are evaluated on the pre-cycle level. A pop on an empty FIFO does not see the same-cycle write.
- Input byte throughput: 1 byte/cycle, with no backpressure.

## Test plan
- Normal stream: two 960-byte packets, header 80 00, seq 1 then 2, SSRC 12345678, payload ramp 0x0000–0x03B3.
  - Required: pkt_ok_cnt=2, fifo_level=948.
  - Required: playing=1 after the first packet.
  - Required: wav_rden pulses yield 0x0000, 0x0001, … each at N+1.
- Header errors:
  - SSRC 12345679 → pkt_drop_cnt=1, FIFO unchanged.
  - Byte 1 = 0x80 (marker only) → accepted.
  - Byte 0 = 0x90 → dropped.
- Length errors:
  - len=12 → drop.
  - len=15 → drop.
  - len=5 with packet ending at byte 4 → drop, parser back in IDLE.
  - A following good packet is accepted in every case.
- Sequence:
  - seq 0xFFFE, 0xFFFF, 0x0000 → seq_gap_cnt=0.
  - Then seq 0x0003 → seq_gap_cnt=1.
- Overflow: three 960-byte packets with no wav_rden → fifo_level=1024, overflow_cnt=398.
- Underflow and prefill:
  - After playback starts, issue 475 wav_rden → the last read outputs 0, underflow_cnt=1, playing=0.
  - Further reads output 0 until the next packet re-prefills.
  - Inject byte-valid gaps randomly; results must be identical.

Source files
------------

// File: rtl/rtp_rx_depack_if.sv
// Byte-stream and DAC-sample bus between the UDP receive path, the RTP depacketizer and the codec.
// Handshake: a byte transfers on every cycle udp_rec_data_valid=1 (no backpressure); wav_rden is a
// request strobe answered one cycle later by a single-cycle wav_out_valid pulse carrying wav_out_data.
interface rtp_rx_depack_if;
    logic        udp_rec_data_valid;
    logic [7:0]  udp_rec_rdata;
    logic [15:0] udp_rec_data_length;
    logic        wav_rden;
    logic [15:0] wav_out_data;
    logic        wav_out_valid;

    modport master (
        output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, wav_rden,
        input  wav_out_data, wav_out_valid
    );

    modport slave (
        input  udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, wav_rden,
        output wav_out_data, wav_out_valid
    );
endinterface

// File: rtl/rtp_rx_depack.sv
// RTP receive depacketizer: validates the 12-byte header, unpacks big-endian samples into a
// jitter FIFO and replays them to the DAC with prefill and underflow recovery.
module rtp_rx_depack #(
    parameter logic [15:0] RTP_HEADER_PARAM = 16'h8080,
    parameter logic [31:0] SSRC             = 32'h12345678,
    parameter int          FIFO_DEPTH       = 1024,
    parameter int          PREFILL          = 474
) (
    input  logic                          clk,
    input  logic                          rst_n,
    rtp_rx_depack_if.slave                bus,
    output logic                          playing,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   pkt_ok_cnt,
    output logic [15:0]                   pkt_drop_cnt,
    output logic [15:0]                   seq_gap_cnt,
    output logic [15:0]                   overflow_cnt,
    output logic [15:0]                   underflow_cnt,
    output logic [1:0]                    parser_state
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL   = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] PREFILL_LVL = LVL_W'(PREFILL);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DISCARD} state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       idx_q, idx_d;
    logic              bad_q, bad_d;
    logic [7:0]        seq_hi_q, seq_hi_d;
    logic [15:0]       seq_q, seq_d;
    logic [15:0]       prev_seq_q, prev_seq_d;
    logic              prev_vld_q, prev_vld_d;
    logic [7:0]        hi_q, hi_d;
    logic              inc_ok, inc_drop, inc_gap, wr_req;
    logic              byte_bad, last_byte;

    logic [15:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              playing_q, playing_d;
    logic              full, empty, do_wr, do_pop, ovf, unf;
    logic [15:0]       out_data_q, out_data_d;
    logic              out_valid_q;
    logic [15:0]       ok_q, drop_q, gap_q, ovf_q, unf_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    assign last_byte = (idx_q == len_q - 16'd1);

    always_comb begin
        byte_bad = 1'b0;
        case (idx_q)
            16'd1:   byte_bad = (bus.udp_rec_rdata[6:0] != RTP_HEADER_PARAM[6:0]);
            16'd8:   byte_bad = (bus.udp_rec_rdata != SSRC[31:24]);
            16'd9:   byte_bad = (bus.udp_rec_rdata != SSRC[23:16]);
            16'd10:  byte_bad = (bus.udp_rec_rdata != SSRC[15:8]);
            16'd11:  byte_bad = (bus.udp_rec_rdata != SSRC[7:0]);
            default: byte_bad = 1'b0;
        endcase
    end

    // idx_q holds the index of the byte currently on the bus once a packet has started.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        bad_d      = bad_q;
        seq_hi_d   = seq_hi_q;
        seq_d      = seq_q;
        prev_seq_d = prev_seq_q;
        prev_vld_d = prev_vld_q;
        hi_d       = hi_q;
        inc_ok     = 1'b0;
        inc_drop   = 1'b0;
        inc_gap    = 1'b0;
        wr_req     = 1'b0;
        if (bus.udp_rec_data_valid) begin
            case (state_q)
                S_IDLE: begin
                    len_d = bus.udp_rec_data_length;
                    idx_d = 16'd1;
                    bad_d = (bus.udp_rec_data_length < 16'd14) || bus.udp_rec_data_length[0]
                            || (bus.udp_rec_rdata != RTP_HEADER_PARAM[15:8]);
                    if (bus.udp_rec_data_length <= 16'd1) inc_drop = 1'b1;
                    else                                  state_d  = S_HDR;
                end
                S_HDR: begin
                    idx_d = idx_q + 16'd1;
                    bad_d = bad_q | byte_bad;
                    if (idx_q == 16'd2) seq_hi_d = bus.udp_rec_rdata;
                    if (idx_q == 16'd3) seq_d    = {seq_hi_q, bus.udp_rec_rdata};
                    if (last_byte) begin
                        inc_drop = 1'b1;
                        state_d  = S_IDLE;
                    end else if (idx_q == 16'd11) begin
                        if (bad_q | byte_bad) begin
                            inc_drop = 1'b1;
                            state_d  = S_DISCARD;
                        end else begin
                            inc_ok     = 1'b1;
                            inc_gap    = prev_vld_q && (seq_q != prev_seq_q + 16'd1);
                            prev_seq_d = seq_q;
                            prev_vld_d = 1'b1;
                            state_d    = S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    idx_d = idx_q + 16'd1;
                    if (!idx_q[0]) hi_d   = bus.udp_rec_rdata;
                    else           wr_req = 1'b1;
                    if (last_byte) state_d = S_IDLE;
                end
                default: begin
                    idx_d = idx_q + 16'd1;
                    if (last_byte) state_d = S_IDLE;
                end
            endcase
        end
    end

    // Full/empty come from the pre-cycle level, so a pop never sees a same-cycle write.
    always_comb begin
        full      = (level_q == DEPTH_LVL);
        empty     = (level_q == '0);
        do_wr     = wr_req & ~full;
        ovf       = wr_req & full;
        do_pop    = bus.wav_rden & playing_q & ~empty;
        unf       = bus.wav_rden & playing_q & empty;
        level_d   = level_q + LVL_W'(do_wr) - LVL_W'(do_pop);
        playing_d = playing_q;
        if (unf)                         playing_d = 1'b0;
        else if (level_q >= PREFILL_LVL) playing_d = 1'b1;
        out_data_d = out_data_q;
        if (bus.wav_rden) out_data_d = do_pop ? mem[rd_ptr_q] : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= {hi_q, bus.udp_rec_rdata};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            bad_q       <= 1'b0;
            seq_hi_q    <= '0;
            seq_q       <= '0;
            prev_seq_q  <= '0;
            prev_vld_q  <= 1'b0;
            hi_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            playing_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ok_q        <= '0;
            drop_q      <= '0;
            gap_q       <= '0;
            ovf_q       <= '0;
            unf_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            bad_q       <= bad_d;
            seq_hi_q    <= seq_hi_d;
            seq_q       <= seq_d;
            prev_seq_q  <= prev_seq_d;
            prev_vld_q  <= prev_vld_d;
            hi_q        <= hi_d;
            wr_ptr_q    <= wr_ptr_q + AW'(do_wr);
            rd_ptr_q    <= rd_ptr_q + AW'(do_pop);
            level_q     <= level_d;
            playing_q   <= playing_d;
            out_data_q  <= out_data_d;
            out_valid_q <= bus.wav_rden;
            ok_q        <= sat_inc(ok_q, inc_ok);
            drop_q      <= sat_inc(drop_q, inc_drop);
            gap_q       <= sat_inc(gap_q, inc_gap);
            ovf_q       <= sat_inc(ovf_q, ovf);
            unf_q       <= sat_inc(unf_q, unf);
        end
    end

    assign bus.wav_out_data  = out_data_q;
    assign bus.wav_out_valid = out_valid_q;
    assign playing           = playing_q;
    assign fifo_level        = level_q;
    assign pkt_ok_cnt        = ok_q;
    assign pkt_drop_cnt      = drop_q;
    assign seq_gap_cnt       = gap_q;
    assign overflow_cnt      = ovf_q;
    assign underflow_cnt     = unf_q;
    assign parser_state      = state_q;
endmodule

// File: tb/tb_rtp_rx_depack.sv
// Directed bench for rtp_rx_depack: header/length/sequence validation, FIFO fill and playback.
module tb_rtp_rx_depack;
    logic        clk;
    logic        rst_n;
    logic        playing;
    logic [10:0] fifo_level;
    logic [15:0] pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt, overflow_cnt, underflow_cnt;
    logic [1:0]  parser_state;
    int          checks;
    int          errors;

    rtp_rx_depack_if bus ();

    rtp_rx_depack dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .playing       (playing),
        .fifo_level    (fifo_level),
        .pkt_ok_cnt    (pkt_ok_cnt),
        .pkt_drop_cnt  (pkt_drop_cnt),
        .seq_gap_cnt   (seq_gap_cnt),
        .overflow_cnt  (overflow_cnt),
        .underflow_cnt (underflow_cnt),
        .parser_state  (parser_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input logic [15:0] len, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.udp_rec_data_valid  = 1'b1;
        bus.udp_rec_rdata       = b;
        bus.udp_rec_data_length = len;
        @(negedge clk);
        bus.udp_rec_data_valid  = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [15:0] seq, input logic [31:0] ssrc,
                            input logic [15:0] start, input bit gaps);
        logic [7:0]  b;
        logic [15:0] s;
        for (int i = 0; i < len; i++) begin
            case (i)
                0:  b = b0;
                1:  b = b1;
                2:  b = seq[15:8];
                3:  b = seq[7:0];
                8:  b = ssrc[31:24];
                9:  b = ssrc[23:16];
                10: b = ssrc[15:8];
                11: b = ssrc[7:0];
                default: begin
                    s = start + 16'((i - 12) / 2);
                    b = (i < 12) ? 8'h00 : ((i % 2 == 0) ? s[15:8] : s[7:0]);
                end
            endcase
            send_byte(b, 16'(len), gaps);
        end
    endtask

    task automatic good_pkt(input int len, input logic [15:0] seq, input logic [15:0] start,
                            input bit gaps);
        send_pkt(len, 8'h80, 8'h00, seq, 32'h12345678, start, gaps);
    endtask

    // One request strobe; on return the response cycle is visible.
    task automatic do_read();
        bus.wav_rden = 1'b1;
        @(negedge clk);
        bus.wav_rden = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        good_pkt(16, 16'd7, 16'h1111, 1'b0);
        idle(3);
        do_reset();
        checks++; if (bus.wav_out_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h exp 0000", bus.wav_out_data); end
        checks++; if (bus.wav_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.wav_out_valid); end
        checks++; if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing got %b exp 0", playing); end
        checks++; if (fifo_level !== 11'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        checks++; if ({pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt, overflow_cnt, underflow_cnt} !== 80'h0) begin
            errors++; $display("FAIL reset_counters got %h %h %h %h %h exp all 0", pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt, overflow_cnt, underflow_cnt);
        end
        checks++; if (parser_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", parser_state); end
    endtask

    task automatic test_normal(input bit gaps);
        do_reset();
        good_pkt(960, 16'd1, 16'h0000, gaps);
        idle(3);
        checks++; if (playing !== 1'b1) begin errors++; $display("FAIL normal_playing got %b exp 1 (gaps=%0d)", playing, gaps); end
        checks++; if (fifo_level !== 11'd474) begin errors++; $display("FAIL normal_level1 got %0d exp 474", fifo_level); end
        good_pkt(960, 16'd2, 16'd474, gaps);
        idle(3);
        checks++; if (pkt_ok_cnt !== 16'd2) begin errors++; $display("FAIL normal_ok got %0d exp 2", pkt_ok_cnt); end
        checks++; if (fifo_level !== 11'd948) begin errors++; $display("FAIL normal_level2 got %0d exp 948", fifo_level); end
        checks++; if (pkt_drop_cnt !== 16'd0 || seq_gap_cnt !== 16'd0) begin errors++; $display("FAIL normal_nodrop got drop %0d gap %0d exp 0 0", pkt_drop_cnt, seq_gap_cnt); end
        for (int k = 0; k < 4; k++) begin
            do_read();
            checks++; if (bus.wav_out_valid !== 1'b1 || bus.wav_out_data !== 16'(k)) begin
                errors++; $display("FAIL normal_read%0d got v=%b d=%h exp v=1 d=%h", k, bus.wav_out_valid, bus.wav_out_data, 16'(k));
            end
        end
        idle(1);
        checks++; if (bus.wav_out_valid !== 1'b0 || bus.wav_out_data !== 16'h0003) begin
            errors++; $display("FAIL normal_hold got v=%b d=%h exp v=0 d=0003", bus.wav_out_valid, bus.wav_out_data);
        end
        checks++; if (fifo_level !== 11'd944) begin errors++; $display("FAIL normal_level3 got %0d exp 944", fifo_level); end
    endtask

    task automatic test_hdr_errors();
        do_reset();
        send_pkt(16, 8'h80, 8'h00, 16'd1, 32'h12345679, 16'h0, 1'b0);
        idle(3);
        checks++; if (pkt_drop_cnt !== 16'd1 || fifo_level !== 11'd0) begin errors++; $display("FAIL hdr_ssrc got drop %0d lvl %0d exp 1 0", pkt_drop_cnt, fifo_level); end
        send_pkt(16, 8'h80, 8'h80, 16'd2, 32'h12345678, 16'h0, 1'b0);
        idle(3);
        checks++; if (pkt_ok_cnt !== 16'd1 || fifo_level !== 11'd2) begin errors++; $display("FAIL hdr_marker got ok %0d lvl %0d exp 1 2", pkt_ok_cnt, fifo_level); end
        send_pkt(16, 8'h90, 8'h00, 16'd3, 32'h12345678, 16'h0, 1'b0);
        idle(3);
        checks++; if (pkt_drop_cnt !== 16'd2 || fifo_level !== 11'd2) begin errors++; $display("FAIL hdr_byte0 got drop %0d lvl %0d exp 2 2", pkt_drop_cnt, fifo_level); end
        good_pkt(16, 16'd4, 16'h0, 1'b0);
        idle(3);
        checks++; if (pkt_ok_cnt !== 16'd2 || fifo_level !== 11'd4) begin errors++; $display("FAIL hdr_recover got ok %0d lvl %0d exp 2 4", pkt_ok_cnt, fifo_level); end
    endtask

    task automatic test_len_errors();
        do_reset();
        good_pkt(12, 16'd1, 16'h0, 1'b0);
        good_pkt(16, 16'd2, 16'h0, 1'b0);
        idle(3);
        checks++; if (pkt_drop_cnt !== 16'd1 || pkt_ok_cnt !== 16'd1) begin errors++; $display("FAIL len12 got drop %0d ok %0d exp 1 1", pkt_drop_cnt, pkt_ok_cnt); end
        good_pkt(15, 16'd3, 16'h0, 1'b0);
        good_pkt(16, 16'd4, 16'h0, 1'b0);
        idle(3);
        checks++; if (pkt_drop_cnt !== 16'd2 || pkt_ok_cnt !== 16'd2) begin errors++; $display("FAIL len15 got drop %0d ok %0d exp 2 2", pkt_drop_cnt, pkt_ok_cnt); end
        good_pkt(5, 16'd5, 16'h0, 1'b0);
        idle(2);
        checks++; if (pkt_drop_cnt !== 16'd3 || parser_state !== 2'd0) begin errors++; $display("FAIL len5 got drop %0d state %0d exp 3 0", pkt_drop_cnt, parser_state); end
        good_pkt(16, 16'd6, 16'h0, 1'b0);
        idle(3);
        checks++; if (pkt_ok_cnt !== 16'd3 || fifo_level !== 11'd6) begin errors++; $display("FAIL len_recover got ok %0d lvl %0d exp 3 6", pkt_ok_cnt, fifo_level); end
    endtask

    task automatic test_seq();
        do_reset();
        good_pkt(16, 16'hFFFE, 16'h0, 1'b0);
        good_pkt(16, 16'hFFFF, 16'h0, 1'b0);
        good_pkt(16, 16'h0000, 16'h0, 1'b0);
        idle(2);
        checks++; if (seq_gap_cnt !== 16'd0) begin errors++; $display("FAIL seq_wrap got %0d exp 0", seq_gap_cnt); end
        good_pkt(16, 16'h0003, 16'h0, 1'b0);
        idle(2);
        checks++; if (seq_gap_cnt !== 16'd1) begin errors++; $display("FAIL seq_gap got %0d exp 1", seq_gap_cnt); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int p = 0; p < 3; p++) good_pkt(960, 16'(p + 1), 16'(p * 474), 1'b0);
        idle(3);
        checks++; if (fifo_level !== 11'd1024) begin errors++; $display("FAIL ovf_level got %0d exp 1024", fifo_level); end
        checks++; if (overflow_cnt !== 16'd398) begin errors++; $display("FAIL ovf_count got %0d exp 398", overflow_cnt); end
        checks++; if (pkt_ok_cnt !== 16'd3) begin errors++; $display("FAIL ovf_ok got %0d exp 3", pkt_ok_cnt); end
    endtask

    task automatic test_underflow();
        do_reset();
        good_pkt(960, 16'd1, 16'h0000, 1'b1);
        idle(3);
        checks++; if (playing !== 1'b1) begin errors++; $display("FAIL unf_start got %b exp 1", playing); end
        for (int k = 0; k < 474; k++) begin
            do_read();
            checks++; if (bus.wav_out_valid !== 1'b1 || bus.wav_out_data !== 16'(k)) begin
                errors++; $display("FAIL unf_read%0d got v=%b d=%h exp v=1 d=%h", k, bus.wav_out_valid, bus.wav_out_data, 16'(k));
            end
        end
        do_read();
        checks++; if (bus.wav_out_valid !== 1'b1 || bus.wav_out_data !== 16'h0) begin errors++; $display("FAIL unf_last got v=%b d=%h exp v=1 d=0000", bus.wav_out_valid, bus.wav_out_data); end
        checks++; if (underflow_cnt !== 16'd1 || playing !== 1'b0) begin errors++; $display("FAIL unf_flag got cnt %0d play %b exp 1 0", underflow_cnt, playing); end
        idle(1);
        do_read();
        checks++; if (bus.wav_out_data !== 16'h0 || underflow_cnt !== 16'd1) begin errors++; $display("FAIL unf_idle got d=%h cnt %0d exp 0000 1", bus.wav_out_data, underflow_cnt); end
        good_pkt(960, 16'd2, 16'h0100, 1'b1);
        idle(3);
        checks++; if (playing !== 1'b1) begin errors++; $display("FAIL unf_refill got %b exp 1", playing); end
        do_read();
        checks++; if (bus.wav_out_data !== 16'h0100) begin errors++; $display("FAIL unf_resume got %h exp 0100", bus.wav_out_data); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.udp_rec_data_valid  = 1'b0;
        bus.udp_rec_rdata       = 8'h00;
        bus.udp_rec_data_length = 16'h0;
        bus.wav_rden            = 1'b0;
        test_reset();
        test_normal(1'b0);
        test_normal(1'b1);
        test_hdr_errors();
        test_len_errors();
        test_seq();
        test_overflow();
        test_underflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
